pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline sequencing controller for the ID/EX decode register and the front end of the RISC-V pipeline. It detects load-use hazards, sequences multi-cycle multiplies resident in EX, and handles taken branch/JAL redirects. Its outputs are PC write enable, IF/ID enable/flush, and ID/EX hold/flush. It sits beside the decode stage and reads the ID-stage operand numbers plus the EX-stage control outputs of the decode register.

## Interface
- MUL_LAT, 4, total EX-stage cycles of a multiply; legal range 2..16
- CNT_W, 16, width of the stall-cycle performance counter
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- id_nr1_i  in  5  rs1 number of instruction in ID
- id_nr2_i  in  5  rs2 number of instruction in ID
- ex_mem_rd_i  in  1  instruction in EX is a load (decode register Mem_Rd output)
- ex_regd_i  in  5  destination register of instruction in EX
- ex_mul_i  in  1  instruction in EX is a multiply (decode register Mul output)
- ex_branch_taken_i  in  1  branch/JAL in EX resolved taken
- pc_we_o  out  1  PC write enable
- ifid_we_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  IF/ID register clear
- idex_hold_o  out  1  ID/EX register hold (enable low)
- idex_flush_o  out  1  ID/EX register clear (bubble insert)
- mul_busy_o  out  1  multiply sequence in progress
- mul_done_o  out  1  one-cycle pulse on last multiply cycle
- stall_cycles_o  out  CNT_W  saturating count of cycles with pc_we_o low since reset

## Operation
- States: RUN, MUL_WAIT. Down-counter mul_cnt, width 4.
- Priority per cycle: reset > multiply hold > branch redirect > load-use stall > normal.
- Load-use hazard is: ex_mem_rd_i=1, ex_regd_i≠0, and ex_regd_i equals id_nr1_i or id_nr2_i.
- RUN, normal: pc_we=1, ifid_we=1, all flush/hold=0.
- RUN, ex_mul_i=1:
  - Outputs: pc_we=0, ifid_we=0, idex_hold=1, mul_busy=1.
  - Next state: MUL_WAIT, with mul_cnt loaded to MUL_LAT-2.
- MUL_WAIT, mul_cnt≠0: same hold outputs; mul_cnt decrements.
- MUL_WAIT, mul_cnt=0:
  - Outputs: normal-advance outputs, with mul_busy=1 and mul_done=1.
  - Next state: RUN.
- ex_branch_taken_i in MUL_WAIT is ignored (illegal: EX holds a multiply).
- RUN, branch taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1.
- RUN, load-use (no branch, no mul): pc_we=0, ifid_we=0, idex_flush=1, idex_hold=0; exactly one bubble.
- stall_cycles increments on every clock with pc_we_o=0 and reset low; it holds at all-ones.

## Timing
- All hazard outputs are combinational from the current state, mul_cnt and inputs, so they are valid in the same cycle as the hazard.
- State, mul_cnt and stall_cycles update on the rising edge of clk_i.
- While reset_i=1, regardless of clock:
  - State=RUN, mul_cnt=0, stall_cycles=0.
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1.
  - idex_hold=0, mul_busy=0, mul_done=0.
- A multiply occupies EX for exactly MUL_LAT cycles, with hold asserted in the first MUL_LAT-1 of them. The pipeline advances at the end of the last cycle.
- Back-to-back multiplies: the release cycle is in MUL_WAIT, so the same instruction cannot retrigger. The next multiply enters EX one cycle later and starts a fresh sequence from RUN.
- Load-use stall lasts one cycle. The next cycle's EX holds a bubble (ex_mem_rd_i=0), so the stall self-clears.
- x0 destination never stalls.
- Reset asserted mid-multiply aborts the sequence immediately; there is no mul_done pulse.
- The per-cycle stall count includes both multiply-hold cycles and load-use cycles.

## Structure
- Shared pipeline package holds:
  - state encoding (RUN=1'b0, MUL_WAIT=1'b1);
  - register-number width (5);
  - the x0 constant.
- Sub-module hazard_detect: purely combinational load-use compare, producing one bit. All sequencing stays in the top.

## Test plan
- Reset held 3 cycles, then released with no hazards:
  - during reset, outputs equal their reset values;
  - after release, pc_we=1, ifid_we=1, all others 0, stall_cycles=0.
- Load-use: ex_mem_rd=1, ex_regd=5, id_nr2=5 for one cycle:
  - that cycle shows pc_we=0, ifid_we=0, idex_flush=1;
  - next cycle (inputs cleared) returns to normal;
  - stall_cycles=1.
- Same as above but ex_regd=0, id_nr1=0: no stall.
- MUL_LAT=4, ex_mul=1 held 4 cycles:
  - idex_hold=1 for cycles 0..2;
  - cycle 3 shows hold=0 and mul_done=1;
  - stall_cycles increases by 3;
  - a second mul immediately after repeats the identical pattern.
- Branch taken in RUN: pc_we=1, ifid_flush=1, idex_flush=1 for exactly that cycle. Branch taken together with a load-use match still gives the flush outputs, with pc_we=1.
- reset_i pulsed asynchronously (mid-cycle) during MUL_WAIT with mul_cnt=1:
  - outputs go to reset values before the next edge;
  - after release, state is RUN with no mul_done pulse.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/sequencing controller.
//   state_e   : controller state encoding (RUN / MUL_WAIT)
//   RegW      : architectural register-number width
//   RegX0     : register number of the hard-wired zero register
//   MulCntW   : width of the multiply down-counter
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    StRun     = 1'b0,
    StMulWait = 1'b1
  } state_e;

  localparam int unsigned RegW    = 5;
  localparam logic [RegW-1:0] RegX0 = '0;
  localparam int unsigned MulCntW = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare. Purely combinational.
//   mem_rd_i   : instruction in EX is a load
//   regd_i     : destination register of instruction in EX
//   nr1_i      : rs1 of instruction in ID
//   nr2_i      : rs2 of instruction in ID
//   load_use_o : ID consumes the value the EX load has not produced yet
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic            mem_rd_i,
  input  logic [RegW-1:0] regd_i,
  input  logic [RegW-1:0] nr1_i,
  input  logic [RegW-1:0] nr2_i,
  output logic            load_use_o
);

  // x0 is never a real producer, so it can never create a dependency.
  assign load_use_o = mem_rd_i && (regd_i != RegX0) && ((regd_i == nr1_i) || (regd_i == nr2_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle multiply hold
// in EX, and taken branch/JAL redirects.
//   clk_i, reset_i       : clock, asynchronous active-high reset
//   id_nr1_i, id_nr2_i   : source registers of the ID instruction
//   ex_mem_rd_i          : EX instruction is a load
//   ex_regd_i            : EX destination register
//   ex_mul_i             : EX instruction is a multiply
//   ex_branch_taken_i    : EX branch/JAL resolved taken
//   pc_we_o, ifid_we_o   : PC and IF/ID enables
//   ifid_flush_o         : IF/ID clear
//   idex_hold_o          : ID/EX hold
//   idex_flush_o         : ID/EX clear (bubble)
//   mul_busy_o           : multiply sequence in progress
//   mul_done_o           : pulse on last multiply cycle
//   stall_cycles_o       : saturating count of cycles with pc_we_o low
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [RegW-1:0]  id_nr1_i,
  input  logic [RegW-1:0]  id_nr2_i,
  input  logic             ex_mem_rd_i,
  input  logic [RegW-1:0]  ex_regd_i,
  input  logic             ex_mul_i,
  input  logic             ex_branch_taken_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_hold_o,
  output logic             idex_flush_o,
  output logic             mul_busy_o,
  output logic             mul_done_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [MulCntW-1:0] MulLoad = MulCntW'(MUL_LAT - 2);

  state_e             state_q, state_d;
  logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0]   stall_q;
  logic               load_use;

  pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
    .mem_rd_i   (ex_mem_rd_i),
    .regd_i     (ex_regd_i),
    .nr1_i      (id_nr1_i),
    .nr2_i      (id_nr2_i),
    .load_use_o (load_use)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StRun;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    pc_we_o      = 1'b1;
    ifid_we_o    = 1'b1;
    ifid_flush_o = 1'b0;
    idex_hold_o  = 1'b0;
    idex_flush_o = 1'b0;
    mul_busy_o   = 1'b0;
    mul_done_o   = 1'b0;

    if (reset_i) begin
      // Outputs follow reset immediately, independent of the clock.
      state_d      = StRun;
      mul_cnt_d    = '0;
      pc_we_o      = 1'b0;
      ifid_we_o    = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_mul_i) begin
            pc_we_o     = 1'b0;
            ifid_we_o   = 1'b0;
            idex_hold_o = 1'b1;
            mul_busy_o  = 1'b1;
            state_d     = StMulWait;
            mul_cnt_d   = MulLoad;
          end else if (ex_branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
          end else if (load_use) begin
            // One bubble; the bubble reaching EX clears the hazard next cycle.
            pc_we_o      = 1'b0;
            ifid_we_o    = 1'b0;
            idex_flush_o = 1'b1;
          end
        end
        StMulWait: begin
          // Branch input is meaningless here: EX holds the multiply.
          mul_busy_o = 1'b1;
          if (mul_cnt_q != '0) begin
            pc_we_o     = 1'b0;
            ifid_we_o   = 1'b0;
            idex_hold_o = 1'b1;
            mul_cnt_d   = mul_cnt_q - 1'b1;
          end else begin
            // Release cycle: pipeline advances at the end of this cycle.
            mul_done_o = 1'b1;
            state_d    = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else if (!pc_we_o && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MulLat = 4;
  localparam int unsigned CntW   = 4;

  // Output vector order: {pc_we, ifid_we, ifid_flush, idex_hold, idex_flush, mul_busy, mul_done}
  localparam logic [6:0] ExpReset   = 7'b0010100;
  localparam logic [6:0] ExpNormal  = 7'b1100000;
  localparam logic [6:0] ExpLoadUse = 7'b0000100;
  localparam logic [6:0] ExpMulHold = 7'b0001010;
  localparam logic [6:0] ExpMulDone = 7'b1100011;
  localparam logic [6:0] ExpBranch  = 7'b1110100;

  logic            clk;
  logic            reset;
  logic [4:0]      id_nr1, id_nr2, ex_regd;
  logic            ex_mem_rd, ex_mul, ex_branch_taken;
  logic            pc_we, ifid_we, ifid_flush, idex_hold, idex_flush, mul_busy, mul_done;
  logic [CntW-1:0] stall_cycles;
  logic [6:0]      outs;

  int checks;
  int fails;

  pipeline_hazard_ctrl #(
    .MUL_LAT (MulLat),
    .CNT_W   (CntW)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .id_nr1_i          (id_nr1),
    .id_nr2_i          (id_nr2),
    .ex_mem_rd_i       (ex_mem_rd),
    .ex_regd_i         (ex_regd),
    .ex_mul_i          (ex_mul),
    .ex_branch_taken_i (ex_branch_taken),
    .pc_we_o           (pc_we),
    .ifid_we_o         (ifid_we),
    .ifid_flush_o      (ifid_flush),
    .idex_hold_o       (idex_hold),
    .idex_flush_o      (idex_flush),
    .mul_busy_o        (mul_busy),
    .mul_done_o        (mul_done),
    .stall_cycles_o    (stall_cycles)
  );

  assign outs = {pc_we, ifid_we, ifid_flush, idex_hold, idex_flush, mul_busy, mul_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_nr1 = 5'd0; id_nr2 = 5'd0; ex_regd = 5'd0;
    ex_mem_rd = 1'b0; ex_mul = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (outs !== ExpReset) begin
        fails++; $display("FAIL reset_outs cyc%0d got %b want %b", i, outs, ExpReset);
      end
      checks++;
      if (stall_cycles !== 4'd0) begin
        fails++; $display("FAIL reset_stall got %0d want 0", stall_cycles);
      end
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (outs !== ExpNormal) begin
      fails++; $display("FAIL post_reset_outs got %b want %b", outs, ExpNormal);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cycles !== 4'd0) begin
      fails++; $display("FAIL post_reset_stall got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_mem_rd = 1'b1; ex_regd = 5'd5; id_nr1 = 5'd3; id_nr2 = 5'd5; #1;
    checks++;
    if (outs !== ExpLoadUse) begin
      fails++; $display("FAIL load_use_outs got %b want %b", outs, ExpLoadUse);
    end
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (outs !== ExpNormal) begin
      fails++; $display("FAIL load_use_recover got %b want %b", outs, ExpNormal);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cycles !== 4'd1) begin
      fails++; $display("FAIL load_use_stall got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    ex_mem_rd = 1'b1; ex_regd = 5'd0; id_nr1 = 5'd0; id_nr2 = 5'd7; #1;
    checks++;
    if (outs !== ExpNormal) begin
      fails++; $display("FAIL x0_no_stall got %b want %b", outs, ExpNormal);
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (stall_cycles !== 4'd1) begin
      fails++; $display("FAIL x0_stall_count got %0d want 1", stall_cycles);
    end
  endtask

  // Two multiplies back to back; branch is raised during the second one's
  // MUL_WAIT cycles and must have no effect.
  task automatic test_back_to_back_mul();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < MulLat; i++) begin
        @(negedge clk);
        ex_mul = 1'b1;
        ex_branch_taken = (m == 1) && (i > 0);
        #1;
        checks++;
        if (outs !== ((i < MulLat - 1) ? ExpMulHold : ExpMulDone)) begin
          fails++; $display("FAIL mul%0d_cyc%0d got %b want %b", m, i, outs,
                            (i < MulLat - 1) ? ExpMulHold : ExpMulDone);
        end
      end
    end
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (outs !== ExpNormal) begin
      fails++; $display("FAIL mul_after got %b want %b", outs, ExpNormal);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cycles !== 4'd7) begin
      fails++; $display("FAIL mul_stall_count got %0d want 7", stall_cycles);
    end
  endtask

  task automatic test_branch();
    @(negedge clk); ex_branch_taken = 1'b1; #1;
    checks++;
    if (outs !== ExpBranch) begin
      fails++; $display("FAIL branch_outs got %b want %b", outs, ExpBranch);
    end
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (outs !== ExpNormal) begin
      fails++; $display("FAIL branch_one_cycle got %b want %b", outs, ExpNormal);
    end
    @(negedge clk);
    ex_branch_taken = 1'b1; ex_mem_rd = 1'b1; ex_regd = 5'd5; id_nr1 = 5'd5; #1;
    checks++;
    if (outs !== ExpBranch) begin
      fails++; $display("FAIL branch_over_load_use got %b want %b", outs, ExpBranch);
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (stall_cycles !== 4'd7) begin
      fails++; $display("FAIL branch_stall_count got %0d want 7", stall_cycles);
    end
  endtask

  // Three more multiplies add 9 hold cycles: 7 + 9 saturates the 4-bit count at 15.
  task automatic test_saturation();
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < MulLat; i++) begin
        @(negedge clk); ex_mul = 1'b1;
      end
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (stall_cycles !== 4'd15) begin
      fails++; $display("FAIL stall_saturate got %0d want 15", stall_cycles);
    end
  endtask

  task automatic test_async_reset();
    // Cycle 0 in RUN, cycle 1 with mul_cnt=2, cycle 2 with mul_cnt=1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ex_mul = 1'b1;
    end
    #1;
    checks++;
    if (outs !== ExpMulHold) begin
      fails++; $display("FAIL async_pre_hold got %b want %b", outs, ExpMulHold);
    end
    #1; reset = 1'b1; ex_mul = 1'b0; #1;
    checks++;
    if (outs !== ExpReset) begin
      fails++; $display("FAIL async_reset_outs got %b want %b", outs, ExpReset);
    end
    checks++;
    if (stall_cycles !== 4'd0) begin
      fails++; $display("FAIL async_reset_stall got %0d want 0", stall_cycles);
    end
    #1; reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (outs !== ExpNormal) begin
        fails++; $display("FAIL async_after_cyc%0d got %b want %b", i, outs, ExpNormal);
      end
    end
    checks++;
    if (stall_cycles !== 4'd0) begin
      fails++; $display("FAIL async_after_stall got %0d want 0", stall_cycles);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_load_use();
    test_x0();
    test_back_to_back_mul();
    test_branch();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
